// File: rtl/xbus_arbiter_pkg.sv
// Shared xbus definitions: default bus widths (`ADDR_W, `DATA_W) and the arbiter state encoding.
`ifndef XDEFS_VH
`define XDEFS_VH
`define ADDR_W 12
`define DATA_W 32
`endif

package xbus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } xbus_state_e;

endpackage

// File: rtl/xbus_arb_pick.sv
// Combinational winner selection between the two masters.
// XBUS_ARB_RR_EN: round-robin on ties; otherwise fixed priority with the CPU (m0) first.
module xbus_arb_pick (
  input  logic [1:0] m_req,
  input  logic       last_owner,
  output logic       winner
);

`ifdef XBUS_ARB_RR_EN
  // On a tie the master that did not own the bus last wins
  always_comb begin
    winner = 1'b0;
    case (m_req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_owner;
      default: winner = 1'b0;
    endcase
  end
`else
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner;

  // Fixed priority: m0 wins every tie
  always_comb begin
    winner = 1'b0;
    case (m_req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = 1'b0;
      default: winner = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/xbus_arbiter.sv
// Two-master arbiter driving one shared decoder bus through IDLE -> ACCESS -> RESP.
// Define XBUS_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = `ADDR_W,
  parameter int DATA_W   = `DATA_W,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        m_req,
  input  logic [1:0]        m_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_ack,
  output logic [1:0]        m_err,
  output logic [DATA_W-1:0] m_rdata,
  output logic              s_sel,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_trap
);

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX - 1);

  xbus_state_e       state_r, state_nxt_s;
  logic              owner_r;
  logic              last_owner_r;
  logic [7:0]        lock_cnt_r;
  logic [DATA_W-1:0] rdata_r;
  logic              trap_r;
  logic              winner_s;
  logic              lock_go_s;

  xbus_arb_pick u_pick (
    .m_req      (m_req),
    .last_owner (last_owner_r),
    .winner     (winner_s)
  );

  // Owner keeps the bus only while it still locks, requests and has budget left
  assign lock_go_s = m_lock[owner_r] & m_req[owner_r] & (lock_cnt_r < LOCK_LIM);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (m_req != 2'b00) state_nxt_s = ACCESS;
        else                state_nxt_s = IDLE;
      end
      ACCESS: state_nxt_s = RESP;
      RESP: begin
        if (lock_go_s) state_nxt_s = ACCESS;
        else           state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, ownership, lock budget and captured decoder response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      lock_cnt_r   <= 8'd0;
      rdata_r      <= '0;
      trap_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (m_req != 2'b00) owner_r <= winner_s;
        end
        ACCESS: begin
          rdata_r <= s_rdata;
          trap_r  <= s_trap;
        end
        RESP: begin
          if (lock_go_s) begin
            lock_cnt_r <= lock_cnt_r + 8'd1;
          end else begin
            lock_cnt_r   <= 8'd0;
            last_owner_r <= owner_r;
          end
        end
        default: lock_cnt_r <= 8'd0;
      endcase
    end
  end

  // Bus and master-side outputs decoded from the current state and owner
  always_comb begin
    m_gnt   = 2'b00;
    m_ack   = 2'b00;
    m_err   = 2'b00;
    m_rdata = '0;
    s_sel   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    case (state_r)
      ACCESS: begin
        m_gnt[owner_r] = 1'b1;
        s_sel          = 1'b1;
        if (owner_r) begin
          s_we    = m1_we;
          s_addr  = m1_addr;
          s_wdata = m1_wdata;
        end else begin
          s_we    = m0_we;
          s_addr  = m0_addr;
          s_wdata = m0_wdata;
        end
      end
      RESP: begin
        m_gnt[owner_r] = 1'b1;
        m_rdata        = rdata_r;
        if (trap_r) m_err[owner_r] = 1'b1;
        else        m_ack[owner_r] = 1'b1;
      end
      default: m_gnt = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed self-checking bench for xbus_arbiter (LOCK_MAX=4); honours XBUS_ARB_RR_EN for tie expectations.
module tb_xbus_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    m_req = 2'b00;
  logic [1:0]    m_lock = 2'b00;
  logic [AW-1:0] m0_addr = '0;
  logic          m0_we = 1'b0;
  logic [DW-1:0] m0_wdata = '0;
  logic [AW-1:0] m1_addr = '0;
  logic          m1_we = 1'b0;
  logic [DW-1:0] m1_wdata = '0;
  logic [1:0]    m_gnt, m_ack, m_err;
  logic [DW-1:0] m_rdata;
  logic          s_sel, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata = '0;
  logic          s_trap = 1'b0;

  int vecs = 0;
  int errs = 0;

  wire [83:0] all_outs = {m_gnt, m_ack, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata};

  xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_lock(m_lock),
    .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_trap(s_trap)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vecs++;
    if (all_outs !== 84'd0) begin
      errs++; $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({m_gnt, s_sel, m_ack} !== 5'b00000) begin
      errs++; $display("FAIL reset_idle: got %b want 00000", {m_gnt, s_sel, m_ack});
    end
  endtask

  task automatic test_read();
    m0_addr = 12'h010; m0_we = 1'b0; s_rdata = 32'hDEADBEEF; m_req = 2'b01;
    @(negedge clk);
    vecs++;
    if ({m_gnt, s_sel, s_we, s_addr} !== {2'b01, 1'b1, 1'b0, 12'h010}) begin
      errs++; $display("FAIL read_access: got %h want %h", {m_gnt, s_sel, s_we, s_addr}, {2'b01, 1'b1, 1'b0, 12'h010});
    end
    @(negedge clk);
    vecs++;
    if ({m_ack, m_err, m_rdata} !== {2'b01, 2'b00, 32'hDEADBEEF}) begin
      errs++; $display("FAIL read_resp: got %h want %h", {m_ack, m_err, m_rdata}, {2'b01, 2'b00, 32'hDEADBEEF});
    end
    vecs++;
    if ({s_sel, s_addr} !== 13'd0) begin
      errs++; $display("FAIL read_bus_idle_in_resp: got %h want 0", {s_sel, s_addr});
    end
    m_req = 2'b00;
    @(negedge clk);
    vecs++;
    if ({m_gnt, m_ack, m_err} !== 6'd0) begin
      errs++; $display("FAIL read_back_idle: got %b want 000000", {m_gnt, m_ack, m_err});
    end
  endtask

  task automatic test_write();
    m1_addr = 12'h020; m1_we = 1'b1; m1_wdata = 32'h0000005A; m_req = 2'b10;
    #1;
    vecs++;
    if ({s_sel, s_we, s_wdata} !== 34'd0) begin
      errs++; $display("FAIL write_idle_bus: got %h want 0", {s_sel, s_we, s_wdata});
    end
    @(negedge clk);
    vecs++;
    if ({m_gnt, s_sel, s_we, s_addr, s_wdata} !== {2'b10, 1'b1, 1'b1, 12'h020, 32'h0000005A}) begin
      errs++; $display("FAIL write_access: got %h want %h", {m_gnt, s_sel, s_we, s_addr, s_wdata},
                       {2'b10, 1'b1, 1'b1, 12'h020, 32'h0000005A});
    end
    @(negedge clk);
    vecs++;
    if ({m_ack, s_sel, s_we, s_addr, s_wdata} !== {2'b10, 46'd0}) begin
      errs++; $display("FAIL write_resp: got %h want %h", {m_ack, s_sel, s_we, s_addr, s_wdata}, {2'b10, 46'd0});
    end
    m_req = 2'b00; m1_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_trap();
    m1_addr = 12'h030; m_req = 2'b10;
    @(negedge clk);
    vecs++;
    if (m_gnt !== 2'b10) begin
      errs++; $display("FAIL trap_grant: got %b want 10", m_gnt);
    end
    s_trap = 1'b1;
    @(negedge clk);
    vecs++;
    if ({m_ack, m_err} !== 4'b0010) begin
      errs++; $display("FAIL trap_resp: got ack/err %b want 0010", {m_ack, m_err});
    end
    s_trap = 1'b0; m_req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_abort();
    m0_addr = 12'h040; m_req = 2'b01;
    @(negedge clk);
    vecs++;
    if (s_sel !== 1'b1) begin
      errs++; $display("FAIL abort_pre_access: got s_sel %b want 1", s_sel);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (all_outs !== 84'd0) begin
      errs++; $display("FAIL abort_outputs: got %h want 0", all_outs);
    end
    @(negedge clk);
    rst = 1'b0; m_req = 2'b00;
    @(negedge clk);
    vecs++;
    if (all_outs !== 84'd0) begin
      errs++; $display("FAIL abort_no_ack: got %h want 0", all_outs);
    end
    m1_addr = 12'h044; s_rdata = 32'h12345678; m_req = 2'b10;
    @(negedge clk);
    vecs++;
    if ({m_gnt, s_sel, s_addr} !== {2'b10, 1'b1, 12'h044}) begin
      errs++; $display("FAIL abort_next_access: got %h want %h", {m_gnt, s_sel, s_addr}, {2'b10, 1'b1, 12'h044});
    end
    @(negedge clk);
    vecs++;
    if ({m_ack, m_err, m_rdata} !== {2'b10, 2'b00, 32'h12345678}) begin
      errs++; $display("FAIL abort_next_resp: got %h want %h", {m_ack, m_err, m_rdata}, {2'b10, 2'b00, 32'h12345678});
    end
    m_req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_arb();
    logic [1:0] exp_gnt [3];
`ifdef XBUS_ARB_RR_EN
    exp_gnt = '{2'b01, 2'b10, 2'b01};
`else
    exp_gnt = '{2'b01, 2'b01, 2'b01};
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      vecs++;
      if (m_gnt !== exp_gnt[t]) begin
        errs++; $display("FAIL arb_grant_%0d: got %b want %b", t, m_gnt, exp_gnt[t]);
      end
      @(negedge clk);
      vecs++;
      if (m_ack !== exp_gnt[t]) begin
        errs++; $display("FAIL arb_ack_%0d: got %b want %b", t, m_ack, exp_gnt[t]);
      end
      if (t == 2) m_req = 2'b00;
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    logic [1:0] exp_gnt, exp_ack;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_addr = 12'h100; m1_addr = 12'h200; m_lock = 2'b01; m_req = 2'b11;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 8) begin
        exp_gnt = 2'b01;
        exp_ack = (i % 2 == 1) ? 2'b01 : 2'b00;
      end else if (i == 8) begin
        exp_gnt = 2'b00; exp_ack = 2'b00;
      end else begin
        exp_gnt = 2'b10;
        exp_ack = (i == 10) ? 2'b10 : 2'b00;
      end
      vecs++;
      if ({m_gnt, m_ack} !== {exp_gnt, exp_ack}) begin
        errs++; $display("FAIL lock_cycle_%0d: got gnt/ack %b want %b", i, {m_gnt, m_ack}, {exp_gnt, exp_ack});
      end
      if (i == 7) begin
        m_req = 2'b10; m_lock = 2'b00;
      end
    end
    m_req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_trap();
    test_abort();
    test_arb();
    test_lock();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
